// File: rtl/motor_ctrl_pkg.sv
// Shared definitions for the V/f drive sequencer: word width, state encoding,
// default frequency/amplitude limits and the saturated V/f amplitude law.
package motor_ctrl_pkg;

  localparam int unsigned FW          = 7;
  localparam int unsigned F_MIN_DEF   = 5;
  localparam int unsigned F_MAX_DEF   = 100;
  localparam int unsigned AMP_MAX_DEF = 100;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ACCEL = 3'd1,
    ST_RUN   = 3'd2,
    ST_DECEL = 3'd3,
    ST_DWELL = 3'd4,
    ST_FAULT = 3'd5
  } state_t;

  // amp = min(amp_max, v_boost + (f*kvf)>>4); product FW+5 wide, sum FW+6 wide
  function automatic logic [FW-1:0] vf_amp(
    input logic [FW-1:0] f,
    input int unsigned   kvf,
    input int unsigned   v_boost,
    input int unsigned   amp_max
  );
    logic [FW+4:0] prod;
    logic [FW+5:0] sum;
    prod = (FW+5)'(f * kvf);
    sum  = (FW+6)'(prod >> 4) + (FW+6)'(v_boost);
    if (sum > (FW+6)'(amp_max)) begin
      return FW'(amp_max);
    end
    return sum[FW-1:0];
  endfunction

endpackage

// File: rtl/ramp_tick_gen.sv
// Ramp-rate prescaler: counts 0..RAMP_DIV-1 and flags the last count as a
// one-cycle tick; clear_i restarts the count so every state begins a fresh period.
module ramp_tick_gen #(
  parameter int unsigned RAMP_DIV = 500000
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic clear_i,
  output logic tick_o
);

  localparam int unsigned CW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == CW'(RAMP_DIV - 1));

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clear_i || tick_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/vf_ramp_scheduler.sv
// V/f soft-start/soft-stop sequencer: rate-limits the frequency word, derives
// the amplitude word, and sequences direction reversal and fault latching.
module vf_ramp_scheduler
  import motor_ctrl_pkg::*;
#(
  parameter int unsigned RAMP_DIV = 500000,
  parameter int unsigned F_MIN    = F_MIN_DEF,
  parameter int unsigned F_MAX    = F_MAX_DEF,
  parameter int unsigned KVF      = 16,
  parameter int unsigned V_BOOST  = 10,
  parameter int unsigned AMP_MAX  = AMP_MAX_DEF,
  parameter int unsigned DWELL    = 50000000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          run,
  input  logic          dir_cmd,
  input  logic [FW-1:0] f_target,
  input  logic          fault,
  output logic [FW-1:0] f_out,
  output logic [FW-1:0] amp_out,
  output logic          pwm_en,
  output logic          dir_out,
  output logic          at_speed,
  output logic [2:0]    state_o
);

  localparam int unsigned DW = (DWELL > 1) ? $clog2(DWELL) : 1;

  state_t        state_q, state_d;
  logic [FW-1:0] f_q, f_d, amp_q, f_tc;
  logic          pwm_q, pwm_d, dir_q, dir_d, at_q, at_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic          tick, state_change, dir_differs, dwell_done;

  always_comb begin
    f_tc = f_target;
    if (f_target < FW'(F_MIN)) begin
      f_tc = FW'(F_MIN);
    end else if (f_target > FW'(F_MAX)) begin
      f_tc = FW'(F_MAX);
    end
  end

  assign dir_differs  = (dir_cmd != dir_q);
  assign dwell_done   = (dwell_q == DW'(DWELL - 1));
  assign state_change = (state_d != state_q);

  ramp_tick_gen #(
    .RAMP_DIV(RAMP_DIV)
  ) u_tick (
    .clk_i  (clk),
    .reset_i(reset),
    .clear_i(state_change),
    .tick_o (tick)
  );

  // State register together with the datapath registers it sequences
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      f_q     <= '0;
      amp_q   <= '0;
      pwm_q   <= 1'b0;
      dir_q   <= 1'b0;
      at_q    <= 1'b0;
      dwell_q <= '0;
    end else begin
      state_q <= state_d;
      f_q     <= f_d;
      amp_q   <= pwm_q ? vf_amp(f_q, KVF, V_BOOST, AMP_MAX) : '0;
      pwm_q   <= pwm_d;
      dir_q   <= dir_d;
      at_q    <= at_d;
      dwell_q <= dwell_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (fault) begin
      state_d = ST_FAULT;
    end else begin
      case (state_q)
        ST_IDLE:  if (run) state_d = ST_ACCEL;
        ST_ACCEL: begin
          if (!run || dir_differs) state_d = ST_DECEL;
          else if (f_q == f_tc)    state_d = ST_RUN;
        end
        ST_RUN: begin
          if (!run || dir_differs) state_d = ST_DECEL;
          else if (f_q != f_tc)    state_d = ST_ACCEL;
        end
        ST_DECEL: begin
          // Operator re-asserting the same direction resumes from the current speed
          if (run && !dir_differs)            state_d = ST_ACCEL;
          else if (tick && f_q == FW'(F_MIN)) state_d = run ? ST_DWELL : ST_IDLE;
        end
        ST_DWELL: begin
          if (!run)           state_d = ST_IDLE;
          else if (dwell_done) state_d = ST_ACCEL;
        end
        ST_FAULT: if (!run) state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    f_d     = f_q;
    pwm_d   = pwm_q;
    dir_d   = dir_q;
    at_d    = at_q;
    dwell_d = '0;
    if (state_q == ST_DWELL && state_d == ST_DWELL) begin
      dwell_d = dwell_q + DW'(1);
    end
    if (fault) begin
      f_d   = '0;
      pwm_d = 1'b0;
      at_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DWELL: begin
          if (state_d == ST_ACCEL) begin
            dir_d = dir_cmd;
            f_d   = FW'(F_MIN);
            pwm_d = 1'b1;
          end
        end
        ST_ACCEL: begin
          if (state_d == ST_DECEL) begin
            at_d = 1'b0;
          end else if (state_d == ST_RUN) begin
            at_d = 1'b1;
          end else if (tick) begin
            f_d = (f_tc > f_q) ? f_q + FW'(1) : f_q - FW'(1);
          end
        end
        ST_RUN: begin
          if (state_d != ST_RUN) at_d = 1'b0;
        end
        ST_DECEL: begin
          if (state_d == ST_IDLE || state_d == ST_DWELL) begin
            f_d   = '0;
            pwm_d = 1'b0;
          end else if (state_d == ST_DECEL && tick) begin
            f_d = f_q - FW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign f_out    = f_q;
  assign amp_out  = amp_q;
  assign pwm_en   = pwm_q;
  assign dir_out  = dir_q;
  assign at_speed = at_q;
  assign state_o  = state_q;

endmodule

// File: tb/tb_vf_ramp_scheduler.sv
// Bench for vf_ramp_scheduler: directed soft-start/stop/reversal/fault scenarios
// followed by random operator commands, checked cycle by cycle against a reference model.
module tb_vf_ramp_scheduler;

  localparam int RAMP_DIV = 4;
  localparam int DWELL    = 10;
  localparam int F_MIN    = 5;
  localparam int F_MAX    = 100;
  localparam int KVF      = 16;
  localparam int V_BOOST  = 10;
  localparam int AMP_MAX  = 100;
  localparam int W        = 20;

  logic       clk = 1'b0;
  logic       reset, run, dir_cmd, fault;
  logic [6:0] f_target;
  logic [6:0] f_out, amp_out;
  logic       pwm_en, dir_out, at_speed;
  logic [2:0] state_o;

  vf_ramp_scheduler #(
    .RAMP_DIV(RAMP_DIV), .F_MIN(F_MIN), .F_MAX(F_MAX), .KVF(KVF),
    .V_BOOST(V_BOOST), .AMP_MAX(AMP_MAX), .DWELL(DWELL)
  ) dut (
    .clk(clk), .reset(reset), .run(run), .dir_cmd(dir_cmd), .f_target(f_target),
    .fault(fault), .f_out(f_out), .amp_out(amp_out), .pwm_en(pwm_en),
    .dir_out(dir_out), .at_speed(at_speed), .state_o(state_o)
  );

  always #5 clk = ~clk;

  logic [W-1:0] exp_q[$];
  int n_vec = 0;
  int n_bad = 0;

  // Reference model: drive mode, speed, enable, direction, and elapsed time in mode
  int m_state = 0, m_f = 0, m_amp = 0, m_age = 0;
  bit m_pwm = 0, m_dir = 0, m_at = 0;

  function automatic int clamp_target(input int t);
    return (t < F_MIN) ? F_MIN : (t > F_MAX) ? F_MAX : t;
  endfunction

  function automatic int vf_law(input int f, input bit en);
    int a;
    if (!en) return 0;
    a = V_BOOST + (f * KVF) / 16;
    return (a > AMP_MAX) ? AMP_MAX : a;
  endfunction

  task automatic model_step();
    int ns, tgt;
    bit ramp_due;
    if (reset) begin
      m_state = 0; m_f = 0; m_amp = 0; m_age = 0; m_pwm = 0; m_dir = 0; m_at = 0;
      return;
    end
    m_amp    = vf_law(m_f, m_pwm);
    tgt      = clamp_target(int'(f_target));
    ramp_due = ((m_age % RAMP_DIV) == RAMP_DIV - 1);
    ns       = m_state;
    if (fault) begin
      ns = 5; m_f = 0; m_pwm = 0; m_at = 0;
    end else begin
      case (m_state)
        0: if (run) begin ns = 1; m_dir = dir_cmd; m_f = F_MIN; m_pwm = 1; end
        1, 2: begin
          if (!run || dir_cmd != m_dir) begin ns = 3; m_at = 0; end
          else if (m_f == tgt) begin ns = 2; m_at = 1; end
          else if (m_state == 2) begin ns = 1; m_at = 0; end
          else if (ramp_due) m_f = m_f + ((tgt > m_f) ? 1 : -1);
        end
        3: begin
          if (run && dir_cmd == m_dir) ns = 1;
          else if (ramp_due) begin
            if (m_f > F_MIN) m_f = m_f - 1;
            else begin m_f = 0; m_pwm = 0; ns = run ? 4 : 0; end
          end
        end
        4: begin
          if (!run) ns = 0;
          else if (m_age == DWELL - 1) begin ns = 1; m_dir = dir_cmd; m_f = F_MIN; m_pwm = 1; end
        end
        default: if (!run) ns = 0;
      endcase
    end
    m_age   = (ns != m_state) ? 0 : m_age + 1;
    m_state = ns;
  endtask

  // Inputs are set at a falling edge; the model predicts the next rising edge
  task automatic step();
    model_step();
    exp_q.push_back({3'(m_state), m_at, m_dir, m_pwm, 7'(m_amp), 7'(m_f)});
    @(negedge clk);
  endtask

  task automatic cycles(input int n);
    repeat (n) step();
  endtask

  task automatic wait_f(input int want);
    int k = 0;
    while (m_f != want && k < 300) begin
      step();
      k++;
    end
    if (m_f != want) begin
      n_bad++;
      $display("FAIL wait_f: model speed %0d, required %0d within 300 cycles", m_f, want);
    end
  endtask

  initial begin : monitor
    logic [W-1:0] e, g;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        g = {state_o, at_speed, dir_out, pwm_en, amp_out, f_out};
        n_vec++;
        if (g !== e) begin
          n_bad++;
          $display("FAIL outputs @%0t: got st=%0d at=%0b dir=%0b en=%0b amp=%0d f=%0d, required st=%0d at=%0b dir=%0b en=%0b amp=%0d f=%0d",
                   $time, g[19:17], g[16], g[15], g[14], g[13:7], g[6:0],
                   e[19:17], e[16], e[15], e[14], e[13:7], e[6:0]);
        end
      end
    end
  end

  initial begin : driver
    reset = 1'b1; run = 1'b1; dir_cmd = 1'b0; fault = 1'b0; f_target = 7'd35;
    @(negedge clk);
    cycles(3);
    reset = 1'b0;
    cycles(140);                       // soft start 5 -> 35
    f_target = 7'd120; cycles(280);    // clamps at F_MAX, amplitude saturates
    f_target = 7'd3;   cycles(400);    // down to F_MIN, still running
    f_target = 7'd35;  cycles(140);
    run = 1'b0; wait_f(20);
    run = 1'b1; cycles(80);            // resume from mid-decel
    run = 1'b0; cycles(150);
    run = 1'b1; cycles(140);
    dir_cmd = 1'b1; cycles(200);       // reversal through dwell
    cycles(130);
    run = 1'b0; cycles(150);
    run = 1'b1; wait_f(18);
    fault = 1'b1; cycles(1);
    fault = 1'b0; cycles(10);          // run held: fault stays latched
    run = 1'b0; cycles(5);
    repeat (3000) begin
      if ($urandom_range(39, 0) == 0) run = ~run;
      if ($urandom_range(59, 0) == 0) dir_cmd = ~dir_cmd;
      if ($urandom_range(29, 0) == 0) f_target = 7'($urandom_range(127, 0));
      if (fault) begin
        if ($urandom_range(2, 0) == 0) fault = 1'b0;
      end else if ($urandom_range(199, 0) == 0) begin
        fault = 1'b1;
      end
      reset = ($urandom_range(1499, 0) == 0);
      step();
    end
    reset = 1'b0; fault = 1'b0; run = 1'b0;
    cycles(5);
    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/vf_ramp_scheduler.md
Name: vf_ramp_scheduler

Overview:
Volts-per-hertz soft-start/soft-stop sequencer for the 3-phase sine-PWM drive.
- Converts operator commands (run, direction, target frequency) into a rate-limited frequency word for the frequency divider.
- Produces a matching amplitude word for the voltage scaler and the enable for the three PWM phase channels.
- Handles direction reversal through a zero-speed dwell, and latches faults until the operator clears run.

Parameters:
FW, 7, width of frequency and amplitude words
RAMP_DIV, 500000, clk cycles per 1-unit frequency step (10 ms at 50 MHz)
F_MIN, 5, start/stop frequency word
F_MAX, 100, maximum frequency word
KVF, 16, V/f slope in 1/16 amplitude units per frequency unit
V_BOOST, 10, low-speed amplitude boost
AMP_MAX, 100, amplitude saturation (100 = full PWM scale)
DWELL, 50000000, zero-speed cycles before reversal restart (1 s)

Ports:
clk  in  1  system clock (50 MHz)
reset  in  1  synchronous, active-high reset
run  in  1  run request (level)
dir_cmd  in  1  requested rotation direction
f_target  in  FW  requested frequency word
fault  in  1  external fault (level)
f_out  out  FW  frequency word to divider
amp_out  out  FW  amplitude word to voltage scaler
pwm_en  out  1  enable to all three PWM channels
dir_out  out  1  applied direction (phase B/C swap select)
at_speed  out  1  f_out equals clamped target in RUN
state_o  out  3  current state

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- Reset values: state IDLE, f_out=0, amp_out=0, pwm_en=0, dir_out=0, at_speed=0, prescaler=0, dwell counter=0.
- Priority: reset > fault > run/dir commands > ramp tick.
- Target clamp, every cycle: f_tc = clamp(f_target, F_MIN, F_MAX).
- Prescaler: counts 0..RAMP_DIV-1. It emits a 1-cycle tick on wrap and clears to 0 on every state entry.
- state_o encoding: IDLE=0, ACCEL=1, RUN=2, DECEL=3, DWELL=4, FAULT=5.
- IDLE: f_out=0, pwm_en=0.
  - run=1 and fault=0 -> next edge: dir_out<=dir_cmd, f_out<=F_MIN, pwm_en<=1, go to ACCEL.
- ACCEL: on tick, f_out steps ±1 toward f_tc (target may be lowered mid-ramp).
  - f_out==f_tc -> RUN, at_speed<=1.
- RUN: f_tc!=f_out -> ACCEL, at_speed<=0.
- ACCEL or RUN, run=0 or dir_cmd!=dir_out -> DECEL, at_speed<=0.
- DECEL: on tick, f_out-1 while f_out>F_MIN.
  - On a tick with f_out==F_MIN: f_out<=0, pwm_en<=0. Then:
    - run=1 and direction differs -> DWELL
    - otherwise -> IDLE
  - run=1 and dir_cmd==dir_out while in DECEL -> ACCEL immediately, f_out held (resume).
- DWELL: pwm_en=0, counts DWELL cycles.
  - run=0 -> IDLE.
  - Count done -> dir_out<=dir_cmd, f_out<=F_MIN, pwm_en<=1, go to ACCEL.
- FAULT: entered from any state the edge after fault=1.
  - On that same edge: f_out<=0, pwm_en<=0, at_speed<=0.
  - Exits to IDLE only when fault=0 and run=0; run held high keeps FAULT.
- f_out is never outside {0} ∪ [F_MIN, F_MAX]. Steps are exactly ±1 per tick and never skip.
- amp_out: registered from f_out, 1-cycle latency.
  - amp = pwm_en ? min(AMP_MAX, V_BOOST + ((f_out*KVF)>>4)) : 0
  - Intermediate width FW+5; sum computed at FW+6 before saturation.
- dir_out changes only when pwm_en=0 or on the edge that asserts pwm_en.

Decomposition:
- Shared package motor_ctrl_pkg holds:
  - state encoding constants
  - FW
  - default F_MIN, F_MAX, AMP_MAX
  - a function computing the saturated V/f amplitude
- One sub-module, ramp_tick_gen: prescaler with clear input and tick output, parameter RAMP_DIV.

Test Plan:
Bench parameters: RAMP_DIV=4, DWELL=10, F_MIN=5, F_MAX=100, KVF=16, V_BOOST=10, AMP_MAX=100.
1. reset=1 for 3 cycles with run=1 -> all outputs 0, state_o=0. After release -> f_out=5, pwm_en=1 one cycle later.
2. run=1, f_target=35 -> f_out increments every 4 cycles, reaching 35 after 30 ticks (120 cycles ±1). at_speed=1, state_o=2, and amp_out=45 one cycle after f_out=35.
3. f_target=120 -> f_out clamps at 100, amp_out=100 (110 saturated). Then f_target=3 -> ramps down to 5 and holds in RUN, pwm_en=1.
4. At 35, run=0 -> f_out decrements to 5 every 4 cycles, then f_out=0, pwm_en=0, amp_out=0, state_o=0. run=1 again at f_out=20 in DECEL -> ACCEL from 20.
5. At 35, flip dir_cmd -> DECEL to 5, then DWELL for 10 cycles with pwm_en=0. Then dir_out toggles, f_out=5, pwm_en=1, and the drive re-ramps to 35.
6. fault=1 at f_out=18 mid-ACCEL -> next edge f_out=0, pwm_en=0, state_o=5. Release fault with run=1 -> stays 5. Set run=0 -> state_o=0.
